// File: rtl/apb_regif_pkg.sv
// Shared types for the APB-to-regfile bridge: FSM states, error codes, clog2 helper.
// Pure declarations; no logic, no latency, no flow control.
package apb_regif_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DECODE  = 2'd1,
    ERR_ALIGN   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_regif_bridge_if.sv
// APB completer bus plus the req/ack regfile side of the bridge, bundled.
// slave = bridge view, master = system/regfile view.
interface apb_regif_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RANGE_AW   = 12
);
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  logic                    reg_req;
  logic                    reg_we;
  logic [RANGE_AW-1:0]     reg_addr;
  logic [DATA_WIDTH-1:0]   reg_wdata;
  logic [DATA_WIDTH/8-1:0] reg_strb;
  logic                    reg_ack;
  logic [DATA_WIDTH-1:0]   reg_rdata;
  logic [1:0]              err_status;

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, reg_ack, reg_rdata,
    output PRDATA, PREADY, PSLVERR, reg_req, reg_we, reg_addr, reg_wdata, reg_strb, err_status
  );

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, reg_ack, reg_rdata,
    input  PRDATA, PREADY, PSLVERR, reg_req, reg_we, reg_addr, reg_wdata, reg_strb, err_status
  );
endinterface

// File: rtl/apb_regif_timer.sv
// Ack-wait counter: counts enabled cycles, saturates at LIMIT; expired is high in the
// cycle whose count reaches LIMIT. LIMIT=0 ties expired low and builds no counter.
module apb_regif_timer
  import apb_regif_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  if (LIMIT == 0) begin : g_off
    logic unused_tie;
    assign unused_tie = ^{clk, rst_n, clr, en};
    assign expired    = 1'b0;
  end else begin : g_cnt
    localparam int CW = clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0] TOP  = CW'(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
        cnt_d = '0;
      end else if (en && (cnt_q != TOP)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // This cycle's increment is the one that lands on LIMIT.
    assign expired = en && (cnt_q == LAST);
  end

endmodule

// File: rtl/apb_regif_bridge.sv
// APB4 completer to req/ack regfile bridge with range/alignment checks and ack timeout.
// Min transfer SETUP + 2 access cycles; PREADY held low while the regfile withholds reg_ack.
module apb_regif_bridge
  import apb_regif_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    RANGE_AW       = 12,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_regif_bridge_if.slave   bus
);

  localparam int SW      = DATA_WIDTH / 8;
  localparam int ALIGN_W = clog2(SW);
  localparam logic [RANGE_AW-1:0] ALIGN_MASK = RANGE_AW'((1 << ALIGN_W) - 1);

  state_e                state_q, state_d;
  logic [RANGE_AW-1:0]   addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         strb_q, strb_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  err_e                  err_q, err_d;

  logic setup;
  logic in_range;
  logic misalign;
  logic in_req;
  logic tmr_expired;

  assign setup    = bus.PSEL && !bus.PENABLE;
  // Window is aligned to its size, so the upper bits alone decide membership.
  assign in_range = (bus.PADDR >> RANGE_AW) == (BASE_ADDR >> RANGE_AW);
  assign misalign = (bus.PADDR[RANGE_AW-1:0] & ALIGN_MASK) != '0;
  assign in_req   = (state_q == REQ);

  apb_regif_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clr     (!in_req),
    .en      (in_req),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    prdata_d = '0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          addr_d  = bus.PADDR[RANGE_AW-1:0];
          we_d    = bus.PWRITE;
          wdata_d = bus.PWDATA;
          strb_d  = bus.PWRITE ? bus.PSTRB : '1;
          if (!in_range) begin
            state_d = ERR;
            err_d   = ERR_DECODE;
          end else if (misalign) begin
            state_d = ERR;
            err_d   = ERR_ALIGN;
          end else if (bus.PWRITE && (bus.PSTRB == '0)) begin
            state_d = RESP;
            err_d   = ERR_NONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // Abort beats ack, ack beats timeout.
        if (!bus.PSEL) begin
          state_d = IDLE;
        end else if (bus.reg_ack) begin
          state_d = RESP;
          err_d   = ERR_NONE;
          if (!we_q) begin
            prdata_d = bus.reg_rdata;
          end
        end else if (tmr_expired) begin
          state_d = ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prdata_q <= '0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      prdata_q <= prdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.reg_req    = in_req;
  assign bus.reg_we     = in_req && we_q;
  assign bus.reg_addr   = addr_q;
  assign bus.reg_wdata  = wdata_q;
  assign bus.reg_strb   = strb_q;
  assign bus.PRDATA     = prdata_q;
  // A deselected master gets no completion, even from RESP/ERR.
  assign bus.PREADY     = ((state_q == RESP) || (state_q == ERR)) && bus.PSEL;
  assign bus.PSLVERR    = (state_q == ERR) && bus.PSEL;
  assign bus.err_status = err_q;

endmodule

// File: tb/tb_apb_regif_bridge.sv
// Self-checking bench for apb_regif_bridge with a reg/ack responder model and a result scoreboard.
module tb_apb_regif_bridge;

  localparam logic [31:0] BASE = 32'h4000_0000;

  typedef struct packed {
    logic        pslverr;
    logic [31:0] prdata;
    logic [1:0]  err;
    logic [7:0]  acc;
    logic [7:0]  reqs;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } res_t;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];

  int          ack_delay = 99;
  logic [31:0] rf_rdata = '0;
  logic        late_ack = 1'b0;
  int          xfer_id = 0;

  int          run_cnt = 0;
  int          req_total = 0;
  int          cap_id = -1;
  logic        cap_we;
  logic [11:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_strb;

  always #5 PCLK = ~PCLK;

  apb_regif_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RANGE_AW(12)) bus ();

  apb_regif_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .BASE_ADDR      (BASE),
    .RANGE_AW       (12),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  // Regfile responder: acks after ack_delay waiting REQ cycles, records the first request beat.
  always @(negedge PCLK) begin
    if (bus.reg_req === 1'b1) begin
      if (run_cnt == 0) begin
        cap_id    = xfer_id;
        cap_we    = bus.reg_we;
        cap_addr  = bus.reg_addr;
        cap_wdata = bus.reg_wdata;
        cap_strb  = bus.reg_strb;
      end
      bus.reg_ack   = (run_cnt == ack_delay);
      bus.reg_rdata = (run_cnt == ack_delay) ? rf_rdata : 32'hDEAD_BEEF;
      run_cnt++;
      req_total++;
    end else begin
      bus.reg_ack   = late_ack;
      bus.reg_rdata = 32'hDEAD_BEEF;
      run_cnt       = 0;
    end
  end

  function automatic res_t mk(input logic slverr, input logic [31:0] rd, input logic [1:0] es,
                              input int acc, input int reqs, input logic we,
                              input logic [11:0] a, input logic [31:0] wd, input logic [3:0] st);
    res_t e;
    e.pslverr = slverr;
    e.prdata  = rd;
    e.err     = es;
    e.acc     = 8'(acc);
    e.reqs    = 8'(reqs);
    e.we      = we;
    e.addr    = a;
    e.wdata   = wd;
    e.strb    = st;
    return e;
  endfunction

  task automatic apb_setup(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           input logic [3:0] st);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PADDR   = addr;
    bus.PWRITE  = wr;
    bus.PWDATA  = wd;
    bus.PSTRB   = st;
  endtask

  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input logic [3:0] st, input int delay, input logic [31:0] rd,
                          output res_t r);
    int acc;
    int t0;
    @(negedge PCLK);
    xfer_id++;
    ack_delay = delay;
    rf_rdata  = rd;
    t0        = req_total;
    apb_setup(addr, wr, wd, st);
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    acc = 1;
    while (bus.PREADY !== 1'b1 && acc < 20) begin
      @(negedge PCLK);
      acc++;
    end
    r.pslverr = bus.PSLVERR;
    r.prdata  = bus.PRDATA;
    r.err     = bus.err_status;
    r.acc     = 8'(acc);
    r.reqs    = 8'(req_total - t0);
    if (cap_id == xfer_id) begin
      r.we = cap_we; r.addr = cap_addr; r.wdata = cap_wdata; r.strb = cap_strb;
    end else begin
      r.we = 1'b0; r.addr = '0; r.wdata = '0; r.strb = '0;
    end
  endtask

  task automatic bus_idle();
    @(negedge PCLK);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.PREADY !== 1'b0) begin failures++; $display("FAIL reset_pready got=%b exp=0", bus.PREADY); end
    checks++; if (bus.PSLVERR !== 1'b0) begin failures++; $display("FAIL reset_pslverr got=%b exp=0", bus.PSLVERR); end
    checks++; if (bus.PRDATA !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h exp=0", bus.PRDATA); end
    checks++; if (bus.reg_req !== 1'b0) begin failures++; $display("FAIL reset_reg_req got=%b exp=0", bus.reg_req); end
    checks++;
    if ({bus.reg_we, bus.reg_addr, bus.reg_wdata, bus.reg_strb} !== 49'h0) begin
      failures++; $display("FAIL reset_reg_bus got=%h exp=0", {bus.reg_we, bus.reg_addr, bus.reg_wdata, bus.reg_strb});
    end
    checks++; if (bus.err_status !== 2'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", bus.err_status); end
    @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  task automatic test_write();
    res_t r, e;
    exp_q.push_back(mk(1'b0, 32'h0, 2'd0, 2, 1, 1'b1, 12'h010, 32'hA5A5_0001, 4'hF));
    apb_xfer(BASE + 32'h10, 1'b1, 32'hA5A5_0001, 4'hF, 0, 32'h0, r);
    e = exp_q.pop_front();
    checks++; if (r !== e) begin failures++; $display("FAIL write got=%h exp=%h", r, e); end
    bus_idle();
  endtask

  task automatic test_read_wait();
    res_t r, e;
    exp_q.push_back(mk(1'b0, 32'h1234_5678, 2'd0, 5, 4, 1'b0, 12'h004, 32'h0, 4'hF));
    apb_xfer(BASE + 32'h4, 1'b0, 32'h0, 4'h3, 3, 32'h1234_5678, r);
    e = exp_q.pop_front();
    checks++; if (r !== e) begin failures++; $display("FAIL read_wait got=%h exp=%h", r, e); end
    @(negedge PCLK);
    checks++;
    if ({bus.PREADY, bus.PRDATA} !== 33'h0) begin
      failures++; $display("FAIL read_after got=%h exp=0", {bus.PREADY, bus.PRDATA});
    end
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic test_decode();
    res_t r, e;
    exp_q.push_back(mk(1'b1, 32'h0, 2'd1, 1, 0, 1'b0, 12'h0, 32'h0, 4'h0));
    apb_xfer(BASE + 32'h1000, 1'b1, 32'h7777_7777, 4'hF, 0, 32'h0, r);
    e = exp_q.pop_front();
    checks++; if (r !== e) begin failures++; $display("FAIL decode got=%h exp=%h", r, e); end
    bus_idle();
  endtask

  task automatic test_abort();
    logic saw;
    @(negedge PCLK);
    xfer_id++;
    ack_delay = 99;
    apb_setup(BASE + 32'h20, 1'b0, 32'h0, 4'hF);
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    @(negedge PCLK);
    checks++; if (bus.reg_req !== 1'b1) begin failures++; $display("FAIL abort_req_held got=%b exp=1", bus.reg_req); end
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    @(negedge PCLK);
    checks++; if (bus.reg_req !== 1'b0) begin failures++; $display("FAIL abort_req_drop got=%b exp=0", bus.reg_req); end
    saw = 1'b0;
    repeat (6) begin
      saw = saw | bus.PREADY | bus.reg_req;
      @(negedge PCLK);
    end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL abort_quiet got=%b exp=0", saw); end
    checks++; if (bus.err_status !== 2'd1) begin failures++; $display("FAIL abort_err got=%0d exp=1", bus.err_status); end
  endtask

  task automatic test_misalign_zero_strb();
    res_t r1, r2, e;
    exp_q.push_back(mk(1'b1, 32'h0, 2'd2, 1, 0, 1'b0, 12'h0, 32'h0, 4'h0));
    exp_q.push_back(mk(1'b0, 32'h0, 2'd0, 1, 0, 1'b0, 12'h0, 32'h0, 4'h0));
    apb_xfer(BASE + 32'h2, 1'b1, 32'h0000_0011, 4'hF, 0, 32'h0, r1);
    apb_xfer(BASE + 32'h8, 1'b1, 32'h0000_0022, 4'h0, 0, 32'h0, r2);
    e = exp_q.pop_front();
    checks++; if (r1 !== e) begin failures++; $display("FAIL misalign got=%h exp=%h", r1, e); end
    e = exp_q.pop_front();
    checks++; if (r2 !== e) begin failures++; $display("FAIL zero_strb got=%h exp=%h", r2, e); end
    bus_idle();
  endtask

  task automatic test_timeout();
    res_t r, e;
    exp_q.push_back(mk(1'b1, 32'h0, 2'd3, 5, 4, 1'b0, 12'h00C, 32'h0, 4'hF));
    apb_xfer(BASE + 32'hC, 1'b0, 32'h0, 4'hF, 99, 32'h5555_5555, r);
    e = exp_q.pop_front();
    checks++; if (r !== e) begin failures++; $display("FAIL timeout got=%h exp=%h", r, e); end
    bus_idle();
    late_ack = 1'b1;
    repeat (2) @(negedge PCLK);
    late_ack = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({bus.PREADY, bus.PSLVERR, bus.reg_req, bus.err_status} !== 5'b00011) begin
      failures++; $display("FAIL late_ack got=%b exp=00011", {bus.PREADY, bus.PSLVERR, bus.reg_req, bus.err_status});
    end
  endtask

  task automatic test_reset_mid();
    res_t r, e;
    @(negedge PCLK);
    xfer_id++;
    ack_delay = 99;
    apb_setup(BASE + 32'h30, 1'b1, 32'hCAFE_F00D, 4'h5);
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    #2;
    checks++; if (bus.reg_req !== 1'b1) begin failures++; $display("FAIL mid_req_before got=%b exp=1", bus.reg_req); end
    PRESETn = 1'b0;
    #1;
    checks++;
    if ({bus.PREADY, bus.PSLVERR, bus.PRDATA, bus.reg_req, bus.reg_we, bus.reg_addr,
         bus.reg_wdata, bus.reg_strb, bus.err_status} !== 86'h0) begin
      failures++;
      $display("FAIL mid_reset got=%h exp=0", {bus.PREADY, bus.PSLVERR, bus.PRDATA, bus.reg_req,
               bus.reg_we, bus.reg_addr, bus.reg_wdata, bus.reg_strb, bus.err_status});
    end
    @(negedge PCLK);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    PRESETn     = 1'b1;
    exp_q.push_back(mk(1'b0, 32'h0BAD_CAFE, 2'd0, 3, 2, 1'b0, 12'hFFC, 32'h0, 4'hF));
    apb_xfer(BASE + 32'hFFC, 1'b0, 32'h0, 4'h0, 1, 32'h0BAD_CAFE, r);
    e = exp_q.pop_front();
    checks++; if (r !== e) begin failures++; $display("FAIL after_reset got=%h exp=%h", r, e); end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    res_t r[3];
    res_t e;
    exp_q.push_back(mk(1'b0, 32'h0, 2'd0, 2, 1, 1'b1, 12'h100, 32'h0000_0001, 4'hF));
    exp_q.push_back(mk(1'b0, 32'h0, 2'd0, 3, 2, 1'b1, 12'h104, 32'h0000_0002, 4'h3));
    exp_q.push_back(mk(1'b1, 32'h0, 2'd1, 1, 0, 1'b0, 12'h0, 32'h0, 4'h0));
    apb_xfer(BASE + 32'h100, 1'b1, 32'h0000_0001, 4'hF, 0, 32'h0, r[0]);
    apb_xfer(BASE + 32'h104, 1'b1, 32'h0000_0002, 4'h3, 1, 32'h0, r[1]);
    apb_xfer(BASE - 32'h4, 1'b0, 32'h0, 4'hF, 0, 32'h0, r[2]);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (r[i] !== e) begin failures++; $display("FAIL b2b_%0d got=%h exp=%h", i, r[i], e); end
    end
    bus_idle();
  endtask

  initial begin
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PADDR   = '0;
    bus.PWRITE  = 1'b0;
    bus.PWDATA  = '0;
    bus.PSTRB   = '0;
    test_reset();
    test_write();
    test_read_wait();
    test_decode();
    test_abort();
    test_misalign_zero_strb();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
